// File: rtl/sr_latch_ctrl.sv
// Sequencing controller for one clocked SR latch: turns set/clear level requests
// into exclusive S/R pulses, enforces a dead gap, then verifies Q and acknowledges.
module sr_latch_ctrl #(
    parameter int PULSE_W = 2,
    parameter int GAP     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic Q_fb,
    output logic S,
    output logic R,
    output logic ack,
    output logic busy,
    output logic err
);

    localparam int MAX_CNT = (PULSE_W > GAP) ? PULSE_W : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_GAP_W  = 2'd2,
        ST_VERIFY = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             op_set_r;
    logic             last_set_r;
    logic             s_r;
    logic             r_r;
    logic             ack_r;
    logic             busy_r;
    logic             err_r;

    logic             accept_s;
    logic             serve_set_s;

    // Request arbitration in IDLE; a conflict serves the opposite of the last operation
    always_comb begin
        accept_s    = 1'b0;
        serve_set_s = 1'b0;
        if (set_req && clr_req) begin
            accept_s    = 1'b1;
            serve_set_s = ~last_set_r;
        end else if (set_req) begin
            accept_s    = 1'b1;
            serve_set_s = 1'b1;
        end else if (clr_req) begin
            accept_s    = 1'b1;
            serve_set_s = 1'b0;
        end else begin
            accept_s    = 1'b0;
            serve_set_s = 1'b0;
        end
    end

    // Sequencer FSM with registered drives; S and R come from one op bit so they never overlap
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            op_set_r   <= 1'b0;
            last_set_r <= 1'b0;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 1'b0;
                    if (accept_s) begin
                        state_r    <= ST_PULSE;
                        cnt_r      <= CNT_ZERO;
                        op_set_r   <= serve_set_s;
                        last_set_r <= serve_set_s;
                        s_r        <= serve_set_s;
                        r_r        <= ~serve_set_s;
                        busy_r     <= 1'b1;
                    end else begin
                        s_r    <= 1'b0;
                        r_r    <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == PULSE_LAST) begin
                        state_r <= ST_GAP_W;
                        cnt_r   <= CNT_ZERO;
                        s_r     <= 1'b0;
                        r_r     <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_GAP_W: begin
                    s_r <= 1'b0;
                    r_r <= 1'b0;
                    if (cnt_r == GAP_LAST) begin
                        state_r <= ST_VERIFY;
                        cnt_r   <= CNT_ZERO;
                        ack_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_VERIFY: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    s_r     <= 1'b0;
                    r_r     <= 1'b0;
                    if (Q_fb != op_set_r) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= err_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    s_r     <= 1'b0;
                    r_r     <= 1'b0;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign S    = s_r;
    assign R    = r_r;
    assign ack  = ack_r;
    assign busy = busy_r;
    assign err  = err_r;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: default (2,1) and short-pulse (1,3) instances share stimulus and
// are checked every cycle against a timeline model of each operation.
module tb_sr_latch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       stuck = 1'b0;
    logic [1:0] q_lat = 2'b00;
    logic [1:0] qfb;
    logic [1:0] s_o, r_o, ack_o, busy_o, err_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state per instance: k = edges since the accepting edge
    int   pw_c[2]  = '{2, 1};
    int   gap_c[2] = '{1, 3};
    logic m_active[2] = '{1'b0, 1'b0};
    logic m_op[2]     = '{1'b0, 1'b0};
    logic m_last[2]   = '{1'b0, 1'b0};
    logic m_err[2]    = '{1'b0, 1'b0};
    int   m_k[2]      = '{0, 0};

    always #5 clk = ~clk;

    assign qfb[0] = stuck ? 1'b0 : q_lat[0];
    assign qfb[1] = stuck ? 1'b0 : q_lat[1];

    // Behaviour of the physical latch each instance drives
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (s_o[i]) q_lat[i] <= 1'b1;
            else if (r_o[i]) q_lat[i] <= 1'b0;
        end
    end

    sr_latch_ctrl #(.PULSE_W(2), .GAP(1)) dut0 (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .Q_fb(qfb[0]),
        .S(s_o[0]), .R(r_o[0]), .ack(ack_o[0]), .busy(busy_o[0]), .err(err_o[0])
    );

    sr_latch_ctrl #(.PULSE_W(1), .GAP(3)) dut1 (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .Q_fb(qfb[1]),
        .S(s_o[1]), .R(r_o[1]), .ack(ack_o[1]), .busy(busy_o[1]), .err(err_o[1])
    );

    function automatic logic exp_s(int i);
        return m_active[i] && m_op[i] && ((m_k[i] + 1) <= pw_c[i]);
    endfunction

    function automatic logic exp_r(int i);
        return m_active[i] && !m_op[i] && ((m_k[i] + 1) <= pw_c[i]);
    endfunction

    function automatic logic exp_ack(int i);
        return m_active[i] && ((m_k[i] + 1) == (pw_c[i] + gap_c[i] + 1));
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model across the coming edge using the inputs that edge will sample
    task automatic model_advance();
        for (int i = 0; i < 2; i++) begin
            logic q_now;
            q_now = stuck ? 1'b0 : q_lat[i];
            if (rst) begin
                m_active[i] = 1'b0;
                m_last[i]   = 1'b0;
                m_err[i]    = 1'b0;
                m_k[i]      = 0;
            end else if (!m_active[i]) begin
                if (set_req || clr_req) begin
                    m_active[i] = 1'b1;
                    m_k[i]      = 0;
                    m_op[i]     = (set_req && clr_req) ? !m_last[i] : set_req;
                    m_last[i]   = m_op[i];
                end
            end else if (m_k[i] == pw_c[i] + gap_c[i]) begin
                if (q_now != m_op[i]) m_err[i] = 1'b1;
                m_active[i] = 1'b0;
            end else begin
                m_k[i] = m_k[i] + 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("S%0d", i), s_o[i], exp_s(i));
            chk($sformatf("R%0d", i), r_o[i], exp_r(i));
            chk($sformatf("ack%0d", i), ack_o[i], exp_ack(i));
            chk($sformatf("busy%0d", i), busy_o[i], m_active[i]);
            chk($sformatf("err%0d", i), err_o[i], m_err[i]);
            chk($sformatf("SandR%0d", i), s_o[i] & r_o[i], 1'b0);
        end
    endtask

    task automatic tick(input logic s, input logic c, input logic rs, input logic st);
        set_req = s;
        clr_req = c;
        rst     = rs;
        stuck   = st;
        model_advance();
        @(negedge clk);
        check_all();
    endtask

    // Hold a request until instance 0 acknowledges, then drop it for one cycle
    task automatic do_op(input logic s, input logic c, input logic st);
        int   guard;
        logic seen;
        guard = 0;
        seen  = 1'b0;
        while (!seen && guard < 40) begin
            tick(s, c, 1'b0, st);
            seen = exp_ack(0);
            guard++;
        end
        chk("op_done", seen, 1'b1);
        tick(1'b0, 1'b0, 1'b0, st);
    endtask

    initial begin
        logic       exp_q[3];
        int         acks;
        int         guard;
        logic [31:0] rnd;

        exp_q = '{1'b1, 1'b0, 1'b1};

        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        do_op(1'b1, 1'b0, 1'b0);
        chk("q_after_set", q_lat[0], 1'b1);
        chk("err_after_set", err_o[0], 1'b0);

        do_op(1'b0, 1'b1, 1'b0);
        chk("q_after_clr", q_lat[0], 1'b0);

        // Both requests held: round-robin gives set, clear, set
        acks  = 0;
        guard = 0;
        while (acks < 3 && guard < 60) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            if (exp_ack(0)) begin
                chk($sformatf("rr_q%0d", acks), q_lat[0], exp_q[acks]);
                acks++;
            end
            guard++;
        end
        chk("rr_done", acks == 3, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Q_fb stuck low during a set raises sticky err
        do_op(1'b1, 1'b0, 1'b1);
        chk("err_stuck", err_o[0], 1'b1);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, 1'b0);
        chk("err_sticky", err_o[0], 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("err_cleared", err_o[0], 1'b0);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during the second pulse cycle of a set
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_S_high", s_o[0], 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mid_S_drop", s_o[0], 1'b0);
        chk("mid_busy", busy_o[0], 1'b0);
        do_op(1'b0, 1'b1, 1'b0);
        chk("q_after_rst_clr", q_lat[0], 1'b0);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic including dropped requests, stuck feedback and resets
        for (int n = 0; n < 400; n++) begin
            rnd = $urandom;
            tick(rnd[0], rnd[1], rnd[6:2] == 5'd0, rnd[9:7] == 3'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
